// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path widths, the {pc, ir} queue entry type and a saturating-increment helper.
package cpu_pkg;

    localparam int IADDRWIDTH = 16;
    localparam int IWIDTH     = 16;

    typedef logic [IADDRWIDTH-1:0] iaddr_t;
    typedef logic [IWIDTH-1:0]     iword_t;

    typedef struct packed {
        iaddr_t pc;
        iword_t ir;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with push/pop/flush; head is the registered oldest entry.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [AW:0]  count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; count/pointers alone define validity.
    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= din;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with one outstanding read, a DEPTH-entry {pc, ir} queue and branch redirect.
// Defining IFETCH_PERF_EN adds the perf_fetched/perf_stall saturating counters.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int     DEPTH    = 4,
    parameter iaddr_t RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [IADDRWIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [IWIDTH-1:0]     imem_rdata,
    input  logic                  redirect_valid,
    input  logic [IADDRWIDTH-1:0] redirect_pc,
    output logic                  dec_valid,
    output logic [IWIDTH-1:0]     dec_ir,
    output logic [IADDRWIDTH-1:0] dec_pc,
    input  logic                  dec_ready
`ifdef IFETCH_PERF_EN
   ,output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    iaddr_t       fetch_pc;
    iaddr_t       req_pc;
    logic         outstanding;
    logic         drop;
    logic [CW-1:0] count;
    fetch_entry_t head;
    fetch_entry_t din;
    logic         live;
    logic         issue;
    logic         push;
    logic         pop;

    // A live request already owns a slot, so count+live is the credit-safe occupancy.
    always_comb begin
        live  = outstanding && !drop;
        issue = !rst && !redirect_valid && (!outstanding || imem_rvalid)
              && ((count + CW'(live)) < CW'(DEPTH));
        push  = outstanding && imem_rvalid && !drop && !redirect_valid;
        pop   = dec_valid && dec_ready && !redirect_valid;
        din   = '{pc: req_pc, ir: imem_rdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            fetch_pc    <= redirect_valid ? redirect_pc
                         : issue ? fetch_pc + IADDRWIDTH'(1) : fetch_pc;
            req_pc      <= issue ? fetch_pc : req_pc;
            outstanding <= issue || (outstanding && !imem_rvalid);
            drop        <= redirect_valid ? (outstanding && !imem_rvalid) : (drop && !imem_rvalid);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign dec_valid = (count != '0);
    assign dec_ir    = head.ir;
    assign dec_pc    = head.pc;

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= (dec_valid && dec_ready) ? sat_inc(perf_fetched) : perf_fetched;
            perf_stall   <= (dec_ready && !dec_valid) ? sat_inc(perf_stall) : perf_stall;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench with a fixed-latency memory model; perf checks only when IFETCH_PERF_EN is defined.
module tb_ifetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dec_valid;
    logic [15:0] dec_ir;
    logic [15:0] dec_pc;
    logic        dec_ready;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int lat     = 1;
    int req_cnt = 0;
    int due_q[$];
    logic [15:0] adr_q[$];
    logic [15:0] del_pc[$];
    logic found;

    ifetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ir         (dec_ir),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
`ifdef IFETCH_PERF_EN
       ,.perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1357;
    endfunction

    // Memory: a request seen in cycle c answers in cycle c+lat, in order.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(adr_q[0]);
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0;
        end
    end

    always @(negedge clk) begin
        if (imem_req) begin
            due_q.push_back(cyc + lat);
            adr_q.push_back(imem_addr);
            req_cnt = req_cnt + 1;
        end
        if (dec_valid && dec_ready && !redirect_valid && !rst)
            del_pc.push_back(dec_pc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (4) next();
        rst = 1'b0;
        del_pc.delete();
        req_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        dec_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 16'h0;
        repeat (3) next();
        @(negedge clk);
        chk("reset_req", imem_req, 0);
        chk("reset_valid", dec_valid, 0);

        // Streaming at L=1 with decode always ready
        lat = 1;
        dec_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_req", imem_req, 1);
            chk("t1_addr", imem_addr, k);
            chk("t1_valid", dec_valid, k >= 2);
            if (k >= 2) begin
                chk("t1_pc", dec_pc, k - 2);
                chk("t1_ir", dec_ir, memf(16'(k - 2)));
            end
            next();
        end

        // Backpressure fills exactly DEPTH entries
        dec_ready = 1'b0;
        do_reset();
        repeat (8) next();
        @(negedge clk);
        chk("t2_req_stop", imem_req, 0);
        chk("t2_valid", dec_valid, 1);
        chk("t2_pc_hold", dec_pc, 0);
        chk("t2_ir_hold", dec_ir, memf(16'h0));
        chk("t2_req_cnt", req_cnt, 4);
        next();
        dec_ready = 1'b1;
        repeat (12) next();
        chk("t2_del_cnt", del_pc.size() >= 8, 1);
        for (int i = 0; i < 8; i++)
            chk("t2_order", del_pc[i], i);

        // L=3, redirect while the request to 0x0005 is in flight
        lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 16'h0005) found = 1'b1;
            else next();
        end
        chk("t3_found5", found, 1);
        next();
        next();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        chk("t3_req_supp", imem_req, 0);
        next();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_drop_resp", imem_rvalid, 1);
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 16'h0100);
        next();
        @(negedge clk);
        chk("t3_gap1", dec_valid, 0);
        next();
        next();
        @(negedge clk);
        chk("t3_gap3", dec_valid, 0);
        next();
        @(negedge clk);
        chk("t3_valid", dec_valid, 1);
        chk("t3_pc", dec_pc, 16'h0100);
        chk("t3_ir", dec_ir, memf(16'h0100));
        repeat (8) next();
        chk("t3_del4", del_pc[4], 16'h0004);
        chk("t3_del5", del_pc[5], 16'h0100);
        chk("t3_del6", del_pc[6], 16'h0101);

        // Late response after reset with nothing outstanding
        do_reset();
        repeat (4) next();
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("late_rvalid", imem_rvalid, 1);
        chk("late_req", imem_req, 1);
        chk("late_addr", imem_addr, 16'h0000);
        next();
        @(negedge clk);
        chk("late_ignored", dec_valid, 0);
        repeat (3) next();
        @(negedge clk);
        chk("late_valid", dec_valid, 1);
        chk("late_pc", dec_pc, 16'h0000);
        chk("late_ir", dec_ir, memf(16'h0000));

        // Redirect coinciding with push, pop and a possible issue
        lat = 1;
        dec_ready = 1'b1;
        do_reset();
        repeat (4) next();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0200;
        @(negedge clk);
        chk("t4_pre_pc", dec_pc, 16'h0002);
        chk("t4_req_supp", imem_req, 0);
        next();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_flushed", dec_valid, 0);
        chk("t4_addr", imem_addr, 16'h0200);
        next();
        @(negedge clk);
        chk("t4_empty2", dec_valid, 0);
        next();
        @(negedge clk);
        chk("t4_valid", dec_valid, 1);
        chk("t4_pc", dec_pc, 16'h0200);

        // Address wrap from 0xFFFF
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        @(negedge clk);
        chk("t5_req_supp", imem_req, 0);
        next();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_addr0", imem_addr, 16'hFFFF);
        next();
        @(negedge clk);
        chk("t5_addr1", imem_addr, 16'h0000);
        next();
        @(negedge clk);
        chk("t5_pc0", dec_pc, 16'hFFFF);
        chk("t5_ir0", dec_ir, memf(16'hFFFF));
        next();
        @(negedge clk);
        chk("t5_pc1", dec_pc, 16'h0000);
        next();
        @(negedge clk);
        chk("t5_pc2", dec_pc, 16'h0001);

`ifdef IFETCH_PERF_EN
        // 10 handshakes and 3 starved-ready cycles, then reset mid-stream
        do_reset();
        repeat (12) next();
        dec_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0300;
        next();
        redirect_valid = 1'b0;
        dec_ready = 1'b1;
        next();
        dec_ready = 1'b0;
        @(negedge clk);
        chk("t6_fetched", perf_fetched, 10);
        chk("t6_stall", perf_stall, 3);
        next();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_midstream", dec_valid, 1);
        next();
        @(negedge clk);
        chk("t6_rst_fetched", perf_fetched, 0);
        chk("t6_rst_stall", perf_stall, 0);
        chk("t6_rst_valid", dec_valid, 0);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
